// File: rtl/bp_be_pkg.sv
// bp_be_pkg: shared backend types; issue-queue entry struct and its width macro
`define BP_BE_ISSUE_QUEUE_ENTRY_WIDTH(vaddr_width_mp) ((vaddr_width_mp) + 32)

package bp_be_pkg;
  localparam int bp_vaddr_width_gp = 39;
  localparam int bp_instr_width_gp = 32;

  typedef struct packed {
    logic [bp_vaddr_width_gp-1:0] pc;
    logic [bp_instr_width_gp-1:0] instr;
  } bp_be_issue_queue_entry_s;
endpackage

// File: rtl/bp_be_issue_queue_mem.sv
// bp_be_issue_queue_mem: entry storage, one synchronous write port, one asynchronous read port, no reset
module bp_be_issue_queue_mem #(
    parameter int els_p   = 8,
    parameter int width_p = 71
) (
    input  logic                     clk_i,
    input  logic                     w_v_i,
    input  logic [$clog2(els_p)-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [$clog2(els_p)-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);
    logic [width_p-1:0] r_mem [els_p];

    // write port
    always_ff @(posedge clk_i) begin
        if (w_v_i) r_mem[w_addr_i] <= w_data_i;
    end

    assign r_data_o = r_mem[r_addr_i];
endmodule

// File: rtl/bp_be_issue_queue.sv
// bp_be_issue_queue: in-order FE instruction buffer with commit/roll replay and optional empty-queue bypass
module bp_be_issue_queue
  import bp_be_pkg::*;
#(
  parameter int els_p         = 8,
  parameter int vaddr_width_p = 39
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     fe_instr_v_i,
  input  logic [vaddr_width_p-1:0] fe_pc_i,
  input  logic [31:0]              fe_instr_i,
  output logic                     fe_instr_ready_o,
  input  logic                     issue_ready_i,
  output logic                     issue_v_o,
  output logic [vaddr_width_p-1:0] issue_pc_o,
  output logic [31:0]              issue_instr_o,
  output logic                     fe_nop_v_o,
  input  logic                     commit_v_i,
  input  logic                     roll_v_i,
  input  logic                     flush_i,
  output logic                     empty_o,
  output logic                     full_o
);
  localparam int idx_w   = $clog2(els_p);
  localparam int ptr_w   = idx_w + 1;
  localparam int entry_w = `BP_BE_ISSUE_QUEUE_ENTRY_WIDTH(vaddr_width_p);

  logic [ptr_w-1:0]   r_wptr, r_rptr, r_cptr;
  logic [ptr_w-1:0]   w_occ, w_cptr_n;
  logic [entry_w-1:0] w_rd_data;
  logic               w_enq, w_issue, w_commit, w_qv;

  assign w_occ            = r_wptr - r_cptr;
  assign full_o           = w_occ == ptr_w'(els_p);
  assign empty_o          = r_wptr == r_cptr;
  assign fe_instr_ready_o = ~full_o & ~reset_i;
  assign w_enq            = fe_instr_v_i & fe_instr_ready_o;
  assign w_qv             = r_rptr != r_wptr;
  assign w_commit         = commit_v_i & (r_cptr != r_rptr);
  assign w_cptr_n         = r_cptr + ptr_w'(w_commit);

`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
  logic w_byp;
  assign w_byp                       = ~w_qv & w_enq & ~flush_i & ~roll_v_i;
  assign issue_v_o                   = w_qv | w_byp;
  assign {issue_pc_o, issue_instr_o} = w_byp ? {fe_pc_i, fe_instr_i} : w_rd_data;
`else
  assign issue_v_o                   = w_qv;
  assign {issue_pc_o, issue_instr_o} = w_rd_data;
`endif

  assign fe_nop_v_o = ~issue_v_o;
  assign w_issue    = issue_v_o & issue_ready_i;

  bp_be_issue_queue_mem #(.els_p(els_p), .width_p(entry_w)) mem (
    .clk_i    (clk_i),
    .w_v_i    (w_enq & ~flush_i),
    .w_addr_i (r_wptr[idx_w-1:0]),
    .w_data_i ({fe_pc_i, fe_instr_i}),
    .r_addr_i (r_rptr[idx_w-1:0]),
    .r_data_o (w_rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i || flush_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cptr <= '0;
    end else begin
      r_wptr <= r_wptr + ptr_w'(w_enq);
      r_cptr <= w_cptr_n;
      r_rptr <= roll_v_i ? w_cptr_n : r_rptr + ptr_w'(w_issue);
    end
  end

  illegal_commit: assert property (@(posedge clk_i) disable iff (reset_i || flush_i)
    commit_v_i |-> (r_cptr != r_rptr));
endmodule

// File: tb/tb_bp_be_issue_queue.sv
// tb_bp_be_issue_queue: scoreboard bench for bp_be_issue_queue (honours BP_BE_ISSUE_QUEUE_BYPASS_EN)
module tb_bp_be_issue_queue;
    localparam int els_p = 8;
    localparam int vw    = 39;
    typedef logic [vw+31:0] w_t;

    logic          clk = 1'b0;
    logic          reset_i, fe_instr_v_i, issue_ready_i, commit_v_i, roll_v_i, flush_i;
    logic [vw-1:0] fe_pc_i;
    logic [31:0]   fe_instr_i;
    logic          fe_instr_ready_o, issue_v_o, fe_nop_v_o, empty_o, full_o;
    logic [vw-1:0] issue_pc_o;
    logic [31:0]   issue_instr_o;

    always #5 clk = ~clk;

    bp_be_issue_queue #(.els_p(els_p), .vaddr_width_p(vw)) dut (
        .clk_i            (clk),
        .reset_i          (reset_i),
        .fe_instr_v_i     (fe_instr_v_i),
        .fe_pc_i          (fe_pc_i),
        .fe_instr_i       (fe_instr_i),
        .fe_instr_ready_o (fe_instr_ready_o),
        .issue_ready_i    (issue_ready_i),
        .issue_v_o        (issue_v_o),
        .issue_pc_o       (issue_pc_o),
        .issue_instr_o    (issue_instr_o),
        .fe_nop_v_o       (fe_nop_v_o),
        .commit_v_i       (commit_v_i),
        .roll_v_i         (roll_v_i),
        .flush_i          (flush_i),
        .empty_o          (empty_o),
        .full_o           (full_o)
    );

    w_t m_q[$];
    int m_r;
    int n_tot = 0;
    int n_bad = 0;
    bit chk_en;

    task automatic check(input string tag, input w_t got, input w_t exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] instr_of(input logic [vw-1:0] pc);
        return pc[31:0] ^ 32'h1357_9bdf;
    endfunction

    task automatic drive(input bit v, input logic [vw-1:0] pc, input bit rdy, input bit com, input bit roll, input bit fl);
        fe_instr_v_i  = v;
        fe_pc_i       = pc;
        fe_instr_i    = instr_of(pc);
        issue_ready_i = rdy;
        commit_v_i    = com;
        roll_v_i      = roll;
        flush_i       = fl;
    endtask

    task automatic tick();
        bit ev, er, ef, ee, enq, iss, com;
        w_t exp_e;
        @(negedge clk);
        ef = m_q.size() == els_p;
        ee = m_q.size() == 0;
        er = !ef && !reset_i;
        enq = fe_instr_v_i && er;
        ev = m_r < m_q.size();
        exp_e = ev ? m_q[m_r] : '0;
`ifdef BP_BE_ISSUE_QUEUE_BYPASS_EN
        if (!ev && enq && !flush_i && !roll_v_i) begin
            ev = 1'b1;
            exp_e = {fe_pc_i, fe_instr_i};
        end
`endif
        if (chk_en) begin
            check("ready", w_t'(fe_instr_ready_o), w_t'(er));
            check("full", w_t'(full_o), w_t'(ef));
            check("empty", w_t'(empty_o), w_t'(ee));
            check("issue_v", w_t'(issue_v_o), w_t'(ev));
            check("fe_nop", w_t'(fe_nop_v_o), w_t'(!ev));
            if (ev) check("issue_entry", {issue_pc_o, issue_instr_o}, exp_e);
        end
        iss = ev && issue_ready_i;
        com = commit_v_i && m_r > 0;
        if (reset_i || flush_i) begin
            m_q.delete();
            m_r = 0;
        end else begin
            if (enq) m_q.push_back({fe_pc_i, fe_instr_i});
            if (com) begin
                void'(m_q.pop_front());
                m_r--;
            end
            if (roll_v_i) m_r = 0;
            else if (iss) m_r++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int g = 0; g < 100 && m_q.size() > 0; g++) begin
            drive(0, '0, 1, m_r > 0, 0, 0);
            tick();
        end
        check("drained", w_t'(m_q.size()), w_t'(0));
    endtask

    initial begin
        reset_i = 1'b1;
        drive(0, '0, 0, 0, 0, 0);
        chk_en = 0;
        m_r = 0;
        tick();
        chk_en = 1;
        tick();
        reset_i = 1'b0;
        tick();
        // in-order issue of three packets
        for (int i = 0; i < 3; i++) begin
            drive(1, vw'(39'h1000 + 4 * i), 1, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, '0, 1, 0, 0, 0);
            tick();
        end
        drain();
        // fill to full, then issue one and commit one
        for (int i = 0; i < els_p + 1; i++) begin
            drive(1, vw'(39'h3000 + 4 * i), 0, 0, 0, 0);
            tick();
        end
        drive(1, 39'h3100, 1, 0, 0, 0);
        tick();
        drive(1, 39'h3100, 0, 1, 0, 0);
        tick();
        drive(1, 39'h3100, 0, 0, 0, 0);
        tick();
        drain();
        // issue 5, commit 2, roll, replay
        for (int i = 0; i < 6; i++) begin
            drive(1, vw'(39'h5000 + 4 * i), 0, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 5; i++) begin
            drive(0, '0, 1, 0, 0, 0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, '0, 0, 1, 0, 0);
            tick();
        end
        drive(0, '0, 0, 0, 1, 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, '0, 1, 0, 0, 0);
            tick();
        end
        drain();
        // roll together with commit and issue handshake
        for (int i = 0; i < 4; i++) begin
            drive(1, vw'(39'h6000 + 4 * i), 0, 0, 0, 0);
            tick();
        end
        drive(0, '0, 1, 0, 0, 0);
        tick();
        drive(0, '0, 1, 1, 1, 0);
        tick();
        drive(0, '0, 0, 0, 0, 0);
        tick();
        drain();
        // flush with a simultaneous enqueue
        for (int i = 0; i < 3; i++) begin
            drive(1, vw'(39'h7000 + 4 * i), i == 2, 0, 0, 0);
            tick();
        end
        drive(1, 39'h2000, 1, 1, 0, 1);
        tick();
        drive(0, '0, 1, 0, 0, 0);
        tick();
        drive(1, 39'h2004, 1, 0, 0, 0);
        tick();
        drain();
        // streaming across pointer wrap
        for (int i = 0; i < 3 * els_p; i++) begin
            drive(1, vw'(39'h4000 + 4 * i), 1, m_r > 0, 0, 0);
            tick();
        end
        drain();
        // random mix
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, vw'(39'h8000 + 4 * i), $urandom_range(0, 2) != 0,
                  m_r > 0 && $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 49) == 0);
            tick();
        end
        drain();
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule

// File: doc/bp_be_issue_queue.md
# bp_be_issue_queue

Instruction buffer between the front-end fetch packet stream and the backend instruction decoder. Holds fetched PC/instruction pairs in order, presents the oldest unissued one to the decoder, and drives the decoder's FE-nop input when nothing is ready. Entries are kept until the backend commits them, so a mispredict or exception can rewind issue to the oldest uncommitted instruction and replay from there.

## Interface
- els_p, 8: queue depth; power of two, at least 2.
- vaddr_width_p, 39: PC width.
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- fe_instr_v_i  in  1  FE packet valid.
- fe_pc_i  in  vaddr_width_p  FE packet PC.
- fe_instr_i  in  32  FE packet instruction.
- fe_instr_ready_o  out  1  queue can accept a packet.
- issue_ready_i  in  1  decoder/calculator accepts the presented instruction.
- issue_v_o  out  1  issue_pc_o / issue_instr_o are valid.
- issue_pc_o  out  vaddr_width_p  PC of the oldest unissued entry.
- issue_instr_o  out  32  instruction of the oldest unissued entry; feeds decoder instr_i.
- fe_nop_v_o  out  1  equals ~issue_v_o; feeds decoder fe_nop_v_i.
- commit_v_i  in  1  retire the oldest issued, uncommitted entry.
- roll_v_i  in  1  rewind issue to the oldest uncommitted entry.
- flush_i  in  1  discard all entries.
- empty_o  out  1  no entries held, whether committed-pending or unissued.
- full_o  out  1  els_p entries held.

## Operation
- Pointers: wptr (enqueue), rptr (issue), cptr (commit). Each is log2(els_p)+1 bits, with the MSB used as a wrap bit.
- Occupancy is wptr−cptr, computed modulo 2^(log2(els_p)+1).
- full_o = (occupancy == els_p).
- empty_o = (wptr == cptr).
- fe_instr_ready_o = ~full_o & ~reset_i.
- Enqueue fires when fe_instr_v_i & fe_instr_ready_o: write the entry at wptr, then wptr++.
- issue_v_o = (rptr != wptr). Outputs are an asynchronous read at rptr.
- Issue fires when issue_v_o & issue_ready_i: rptr++.
- Commit: cptr++. Only legal when cptr != rptr. An illegal commit is ignored and fires an assertion.
- Roll: rptr ← cptr, using the post-commit cptr if commit_v_i is asserted in the same cycle. An issue handshake in the same cycle does not advance rptr.
- Flush: wptr = rptr = cptr = 0. An enqueue, issue, or commit in the same cycle is dropped.
- Priority: reset_i > flush_i > roll_v_i > commit/issue/enqueue. Commit, issue and enqueue are mutually independent.
- An enqueue in a roll cycle is written normally.
- Pointer wrap: the index is the low bits; the wrap bit toggles on index overflow.

## Timing
- Reset values, in the cycle after reset_i is sampled high: all pointers 0, issue_v_o=0, fe_nop_v_o=1, empty_o=1, full_o=0, fe_instr_ready_o=1 (it is 0 while reset_i is high).
- Enqueue-to-issue latency: 1 cycle (0 with bypass).
- issue_v_o, full_o and empty_o depend only on registered state. The one exception is the bypass path.
- Reset, flush or roll mid-stream take effect at the next clock edge. Outputs reflect the new pointers in the following cycle.
- Full with a commit in the same cycle: fe_instr_ready_o stays 0 this cycle and rises next cycle.

## Configuration
- BP_BE_ISSUE_QUEUE_BYPASS_EN defined:
  - When rptr == wptr, fe_instr_v_i & fe_instr_ready_o & ~flush_i & ~roll_v_i raises issue_v_o combinationally, with the FE PC/instruction on the outputs.
  - If issue_ready_i is also high, the entry is still written, and wptr and rptr both increment.
- Undefined: no combinational input-to-output path; every instruction spends at least 1 cycle in the queue.

## Structure
- bp_be_pkg holds the entry struct bp_be_issue_queue_entry_s {pc, instr} and its width macro.
- bp_be_rv64_pkg is untouched.
- Sub-module bp_be_issue_queue_mem: els_p × entry storage, 1 synchronous write port, 1 asynchronous read port, no reset.
- Pointer and control logic stay in the top module.

## Test plan
- Reset, then enqueue PCs 0x1000, 0x1004, 0x1008 with issue_ready_i=1 -> issue order 0x1000, 0x1004, 0x1008; first issue_v_o 1 cycle after enqueue; fe_nop_v_o=1 when drained.
- Enqueue 8 with no issue or commit (els_p=8) -> full_o=1, fe_instr_ready_o=0; issue 1 and commit 1 -> fe_instr_ready_o=1 the next cycle.
- Issue 5, commit 2, assert roll_v_i -> next issue_pc_o is the 3rd entry's PC; entries 3–5 re-issue in order.
- Roll in the same cycle as a commit and an issue handshake -> rptr = old cptr+1; the handshaked instruction is presented again.
- flush_i with a simultaneous enqueue of 0x2000 -> empty_o=1, issue_v_o=0 next cycle; 0x2000 is never issued.
- Run 3×els_p enqueue/issue/commit cycles -> no loss or duplication across pointer wrap. With BYPASS_EN: an enqueue into an empty queue gives issue_v_o in the same cycle.
